// File: rtl/systolic_skew_feeder_pkg.sv
// Shared definitions for the systolic skew feeder: default widths, FSM encoding, KW derivation.
// Optional feature macro used by the top: SKEW_FEEDER_PERF_EN.
package systolic_skew_feeder_pkg;

   localparam int unsigned DWIDTH_DEF = 8;
   localparam int unsigned ROWS_DEF   = 4;
   localparam int unsigned K_MAX_DEF  = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FEED  = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Width of a counter able to hold 0..k_max inclusive
   function automatic int unsigned kw_of(input int unsigned k_max);
      return $clog2(k_max + 1);
   endfunction

endpackage

// File: rtl/systolic_skew_feeder_if.sv
// Operand-vector valid/ready stream feeding the skew feeder.
interface systolic_skew_feeder_if #(
   parameter int unsigned DWIDTH = 8,
   parameter int unsigned ROWS   = 4
) ();
   logic                     s_valid;
   logic                     s_ready;
   logic [ROWS*DWIDTH-1:0]   s_data;

   modport master (output s_valid, output s_data, input  s_ready);
   modport slave  (input  s_valid, input  s_data, output s_ready);
endinterface

// File: rtl/systolic_skew_feeder_skew_delay_line.sv
// Fixed-depth shift register with synchronous active-low reset; one lane of the skew.
module skew_delay_line #(
   parameter int unsigned DWIDTH = 8,
   parameter int unsigned DEPTH  = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DWIDTH-1:0] din,
   output logic [DWIDTH-1:0] dout
);

   logic [DWIDTH-1:0] stage [DEPTH];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
         stage[0] <= din;
         for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign dout = stage[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Skews ROWS-wide operand vectors onto the left-edge PE in_a ports, row r delayed r cycles.
// Optional stall counter enabled by defining SKEW_FEEDER_PERF_EN.
module systolic_skew_feeder
   import systolic_skew_feeder_pkg::*;
#(
   parameter  int unsigned DWIDTH = DWIDTH_DEF,
   parameter  int unsigned ROWS   = ROWS_DEF,
   parameter  int unsigned K_MAX  = K_MAX_DEF,
   localparam int unsigned KW     = kw_of(K_MAX)
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic [KW-1:0]          k_len,
   systolic_skew_feeder_if.slave  s,
   output logic [ROWS*DWIDTH-1:0] out_a,
   output logic                   fire,
   output logic                   busy,
   output logic                   done
`ifdef SKEW_FEEDER_PERF_EN
   ,
   output logic [15:0]            stall_cnt
`endif
);

   localparam int unsigned FW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int unsigned VW = ROWS * DWIDTH;

   state_t          state, state_next;
   logic [KW-1:0]   cnt, len, len_in;
   logic [FW-1:0]   fcnt;
   logic            acc;
   logic [VW-1:0]   lane_in;

   assign len_in = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;

   // State register
   always_ff @(posedge clk) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = (k_len == '0) ? DONE : FEED;
         FEED:    if (acc && (cnt == len - KW'(1))) state_next = FLUSH;
         FLUSH:   if (fcnt == FW'(ROWS - 1)) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Handshake and lane injection; bubbles and flush cycles inject zeros
   always_comb begin
      s.s_ready = 1'b0;
      acc       = 1'b0;
      lane_in   = '0;
      if (state == FEED) s.s_ready = 1'b1;
      acc = s.s_valid && (state == FEED);
      if (acc) lane_in = s.s_data;
   end

   // Tile counters and flags aligned with the delay-line outputs
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt  <= '0;
         len  <= '0;
         fcnt <= '0;
         fire <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         if (state == IDLE && start) begin
            cnt <= '0;
            len <= len_in;
         end else if (acc) begin
            cnt <= cnt + KW'(1);
         end
         fcnt <= (state == FLUSH) ? fcnt + FW'(1) : '0;
         fire <= acc;
         busy <= (state_next != IDLE);
         done <= (state_next == DONE);
      end
   end

`ifdef SKEW_FEEDER_PERF_EN
   always_ff @(posedge clk) begin
      if (!reset_n)                                          stall_cnt <= '0;
      else if (state == IDLE && start)                       stall_cnt <= '0;
      else if (state == FEED && !s.s_valid && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
   end
`endif

   for (genvar r = 0; r < ROWS; r++) begin : g_lane
      skew_delay_line #(
         .DWIDTH (DWIDTH),
         .DEPTH  (r + 1)
      ) u_dl (
         .clk     (clk),
         .reset_n (reset_n),
         .din     (lane_in[r*DWIDTH +: DWIDTH]),
         .dout    (out_a[r*DWIDTH +: DWIDTH])
      );
   end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed + randomized bench for systolic_skew_feeder against a tile-level reference model.
module tb_systolic_skew_feeder;

   localparam int unsigned DW   = 8;
   localparam int unsigned ROWS = 4;
   localparam int unsigned KMAX = 16;
   localparam int unsigned KW   = $clog2(KMAX + 1);
   localparam int unsigned VW   = ROWS * DW;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic [KW-1:0] k_len = '0;
   logic [VW-1:0] out_a;
   logic          fire, busy, done;
`ifdef SKEW_FEEDER_PERF_EN
   logic [15:0]   stall_cnt;
`endif

   systolic_skew_feeder_if #(.DWIDTH(DW), .ROWS(ROWS)) bus ();

   systolic_skew_feeder #(.DWIDTH(DW), .ROWS(ROWS), .K_MAX(KMAX)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .k_len     (k_len),
      .s         (bus),
      .out_a     (out_a),
      .fire      (fire),
      .busy      (busy),
      .done      (done)
`ifdef SKEW_FEEDER_PERF_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: tile progress as vectors left to take, drain cycles left, done pending
   int            rem = 0;
   int            drain = 0;
   bit            done_m = 0;
   bit            fire_m = 0;
   int            stall_m = 0;
   logic [VW-1:0] hist [$];   // hist[i] = vector injected i edges ago

   task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [VW-1:0] exp_out();
      logic [VW-1:0] v = '0;
      for (int r = 0; r < int'(ROWS); r++) v[r*DW +: DW] = hist[r][r*DW +: DW];
      return v;
   endfunction

   function automatic logic [VW-1:0] vec_rk(input int k);
      logic [VW-1:0] v = '0;
      for (int r = 0; r < int'(ROWS); r++) v[r*DW +: DW] = {4'(r), 4'(k)};
      return v;
   endfunction

   // One clock: drive inputs, check ready, clock, advance model, check outputs
   task automatic cyc(input bit v, input bit st, input int kl, input logic [VW-1:0] d, input bit rn);
      bit acc;
      @(negedge clk);
      bus.s_valid = v;
      bus.s_data  = d;
      start       = st;
      k_len       = KW'(kl);
      reset_n     = rn;
      #1;
      chk("s_ready", VW'(bus.s_ready), VW'(rem > 0));
      @(posedge clk);
      if (!rn) begin
         rem = 0; drain = 0; done_m = 0; fire_m = 0; stall_m = 0;
         for (int i = 0; i < int'(ROWS); i++) hist[i] = '0;
      end else begin
         acc = v && (rem > 0);
         hist.push_front(acc ? d : '0);
         void'(hist.pop_back());
         fire_m = acc;
         if (done_m) done_m = 0;
         else if (rem > 0) begin
            if (!v && stall_m != 16'hFFFF) stall_m++;
            if (acc) begin
               rem--;
               if (rem == 0) drain = ROWS;
            end
         end else if (drain > 0) begin
            drain--;
            if (drain == 0) done_m = 1;
         end else if (st) begin
            stall_m = 0;
            if (kl == 0) done_m = 1;
            else rem = (kl > int'(KMAX)) ? int'(KMAX) : kl;
         end
      end
      #1;
      chk("out_a", out_a, exp_out());
      chk("fire",  VW'(fire), VW'(fire_m));
      chk("busy",  VW'(busy), VW'(rem > 0 || drain > 0 || done_m));
      chk("done",  VW'(done), VW'(done_m));
`ifdef SKEW_FEEDER_PERF_EN
      chk("stall_cnt", VW'(stall_cnt), VW'(stall_m));
`endif
   endtask

   function automatic logic [VW-1:0] rnd();
      return VW'($urandom);
   endfunction

   initial begin
      for (int i = 0; i < int'(ROWS); i++) hist.push_back('0);
      bus.s_valid = 1'b0;
      bus.s_data  = '0;

      // Reset state
      cyc(0, 0, 0, '0, 0);
      cyc(1, 1, 3, rnd(), 0);
      cyc(0, 0, 0, '0, 1);

      // 1: three vectors, valid held high, tagged lane data
      cyc(0, 1, 3, '0, 1);
      for (int k = 0; k < 3; k++) cyc(1, 0, 0, vec_rk(k), 1);
      for (int i = 0; i < 7; i++) cyc(1, 0, 0, rnd(), 1);

      // 2: valid pattern 1,0,1,1 leaves one bubble
      cyc(0, 1, 3, '0, 1);
      cyc(1, 0, 0, rnd(), 1);
      cyc(0, 0, 0, rnd(), 1);
      cyc(1, 0, 0, rnd(), 1);
      cyc(1, 0, 0, rnd(), 1);
      for (int i = 0; i < 7; i++) cyc(0, 0, 0, rnd(), 1);

      // 3: empty tile
      cyc(1, 1, 0, rnd(), 1);
      for (int i = 0; i < 4; i++) cyc(1, 0, 0, rnd(), 1);

      // 4: oversize length saturates at K_MAX
      cyc(0, 1, 20, '0, 1);
      for (int i = 0; i < 20; i++) cyc(1, 0, 0, rnd(), 1);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, rnd(), 1);

      // 5: start mid-FEED is ignored
      cyc(0, 1, 4, '0, 1);
      cyc(1, 0, 0, rnd(), 1);
      cyc(1, 1, 5, rnd(), 1);
      for (int i = 0; i < 12; i++) cyc(1, 0, 0, rnd(), 1);

      // 6: reset in FLUSH aborts the tile, then a fresh tile runs
      cyc(0, 1, 2, '0, 1);
      cyc(1, 0, 0, rnd(), 1);
      cyc(1, 0, 0, rnd(), 1);
      cyc(0, 0, 0, rnd(), 1);
      cyc(0, 0, 0, rnd(), 0);
      cyc(0, 0, 0, rnd(), 1);
      cyc(0, 0, 0, rnd(), 1);
      cyc(0, 1, 2, '0, 1);
      for (int i = 0; i < 9; i++) cyc(1, 0, 0, rnd(), 1);

      // Randomized traffic
      for (int i = 0; i < 400; i++)
         cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0),
             int'($urandom_range(0, 20)), rnd(), 1'($urandom_range(0, 60) != 0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
